// File: rtl/siso_pkg.sv
// Shared types and sizing helpers for the SISO chain sequencer.
package siso_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_FLUSH = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // Counter must reach WIDTH+DEPTH without wrapping inside a transfer.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned depth);
        return $clog2(width + depth + 2);
    endfunction

endpackage

// File: rtl/siso_bit_ctr.sv
// Loadable up-counter tracking edges since the accept edge, with the
// terminal-count and capture-window compares used by the sequencer.
module siso_bit_ctr
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_width_c_o,
    output logic tc_total_c_o,
    output logic cap_win_c_o
);

    localparam int unsigned CW = cnt_width(WIDTH, DEPTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds k after edge Ek, so these flag the upcoming edge.
    assign tc_width_c_o = (cnt_q == CW'(WIDTH - 1));
    assign tc_total_c_o = (cnt_q == CW'(WIDTH + DEPTH - 1));
    assign cap_win_c_o  = (cnt_q >= CW'(DEPTH));

endmodule

// File: rtl/siso_seq_ctrl.sv
// Sequencer driving a word MSB-first through a DEPTH-flop SISO chain and
// reassembling it from the chain output. Optional SISO_SEQ_LOOPCHECK_EN adds err.
module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             si,
    input  logic             so,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
`ifdef SISO_SEQ_LOOPCHECK_EN
    output logic             err,
`endif
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             si_q, si_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
`ifdef SISO_SEQ_LOOPCHECK_EN
    logic [WIDTH-1:0] sent_q, sent_d;
    logic             err_q, err_d;
`endif

    logic             ctr_clear_c;
    logic             ctr_inc_c;
    logic             tc_width_c;
    logic             tc_total_c;
    logic             cap_win_c;
    logic [WIDTH-1:0] rx_shift_c;

    siso_bit_ctr #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ctr (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (ctr_clear_c),
        .inc_i        (ctr_inc_c),
        .tc_width_c_o (tc_width_c),
        .tc_total_c_o (tc_total_c),
        .cap_win_c_o  (cap_win_c)
    );

    // Shift left with the chain output entering at the LSB.
    assign rx_shift_c = WIDTH'({rx_q, so});

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        out_data_d  = out_data_q;
        si_d        = si_q;
        out_valid_d = 1'b0;
        ctr_clear_c = 1'b0;
        ctr_inc_c   = 1'b0;
`ifdef SISO_SEQ_LOOPCHECK_EN
        sent_d      = sent_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                si_d = 1'b0;
                if (in_valid) begin
                    tx_d        = in_data << 1;
                    si_d        = in_data[WIDTH-1];
                    ctr_clear_c = 1'b1;
                    state_d     = S_SHIFT;
`ifdef SISO_SEQ_LOOPCHECK_EN
                    sent_d      = in_data;
`endif
                end
            end

            S_SHIFT: begin
                ctr_inc_c = 1'b1;
                // Capture can start while still shifting when DEPTH < WIDTH.
                if (cap_win_c) begin
                    rx_d = rx_shift_c;
                end
                if (tc_width_c) begin
                    si_d    = 1'b0;
                    state_d = S_FLUSH;
                end else begin
                    si_d = tx_q[WIDTH-1];
                    tx_d = tx_q << 1;
                end
            end

            S_FLUSH: begin
                ctr_inc_c = 1'b1;
                si_d      = 1'b0;
                if (cap_win_c) begin
                    rx_d = rx_shift_c;
                end
                if (tc_total_c) begin
                    out_data_d  = rx_shift_c;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`ifdef SISO_SEQ_LOOPCHECK_EN
                    err_d       = (rx_shift_c != sent_q);
`endif
                end
            end

            S_DONE: begin
                si_d    = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                si_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            out_data_q  <= '0;
            si_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            out_data_q  <= out_data_d;
            si_q        <= si_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SISO_SEQ_LOOPCHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_q <= '0;
            err_q  <= 1'b0;
        end else begin
            sent_q <= sent_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign si        = si_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
